uart_digit_tx: RTL and testbench

- UART transmitter paired with the digit receiver in the lab5 top.
- Sends eight 4-bit display digits as four 8N1 UART frames, two digits packed per byte, high digit in the upper nibble.
- Sits between the digit register bank (real_num) and the uart_transmit pin.
- Frame format and bit timing match the receiver, so a loopback of this block into the receiver reproduces the digit bank.

---
 rtl/uart_digit_tx.sv | 175 +++++++++++++++++
 tb/tb_uart_digit_tx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_digit_tx.sv
// UART transmitter for the lab5 digit bank: sends the packed digits as 8N1 frames,
// two digits per byte, most significant byte first, with optional idle gap between frames.
module uart_digit_tx #(
    parameter int CLKS_PER_BIT = 10,
    parameter int NUM_BYTES    = 4,
    parameter int GAP_BITS     = 1
) (
    input  logic                   iclk,
    input  logic                   reset_n,
    input  logic                   trig,
    input  logic [8*NUM_BYTES-1:0] digits,
    output logic                   uart_tx,
    output logic                   busy,
    output logic                   done
);

    localparam int BUF_W   = 8 * NUM_BYTES;
    // GAP_CYC is clamped to 1 so the counter and compare value stay well-formed when GAP_BITS=0
    localparam int GAP_CYC = (GAP_BITS > 0) ? CLKS_PER_BIT * GAP_BITS : 1;
    localparam int CNT_MAX = (GAP_CYC > CLKS_PER_BIT) ? GAP_CYC : CLKS_PER_BIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BYTE_W  = $clog2(NUM_BYTES + 1);

    localparam logic [CNT_W-1:0]  BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  GAP_END   = CNT_W'(GAP_CYC - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        GAP
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                trig_q;
    logic [CNT_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    bit_cnt_next;
    logic [2:0]          bit_idx;
    logic [2:0]          bit_idx_next;
    logic [BYTE_W-1:0]   byte_idx;
    logic [BYTE_W-1:0]   byte_idx_next;
    logic [BUF_W-1:0]    shift_buf;
    logic [BUF_W-1:0]    shift_buf_next;
    logic                tx_next;
    logic                busy_next;
    logic                done_next;
    logic [7:0]          cur_byte;
    logic                accept;
    logic                bit_end;

    // The byte on the wire is always the top byte of the snapshot; it shifts up after each stop bit.
    assign cur_byte = shift_buf[BUF_W-1 -: 8];
    assign accept   = trig && !trig_q && (state == IDLE);
    assign bit_end  = (bit_cnt == BIT_END);

    always_ff @(posedge iclk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            trig_q    <= 1'b0;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            shift_buf <= '0;
            uart_tx   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            trig_q    <= trig;
            bit_cnt   <= bit_cnt_next;
            bit_idx   <= bit_idx_next;
            byte_idx  <= byte_idx_next;
            shift_buf <= shift_buf_next;
            uart_tx   <= tx_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

    // Next-state logic also computes the next line level, so uart_tx comes straight from a flop.
    always_comb begin
        state_next     = state;
        bit_cnt_next   = bit_cnt;
        bit_idx_next   = bit_idx;
        byte_idx_next  = byte_idx;
        shift_buf_next = shift_buf;
        tx_next        = uart_tx;
        busy_next      = busy;
        done_next      = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_next     = START;
                    shift_buf_next = digits;
                    bit_cnt_next   = '0;
                    bit_idx_next   = '0;
                    byte_idx_next  = '0;
                    tx_next        = 1'b0;
                    busy_next      = 1'b1;
                end
            end

            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                    bit_idx_next = '0;
                    tx_next      = cur_byte[0];
                end else begin
                    bit_cnt_next = bit_cnt + CNT_W'(1);
                end
            end

            DATA: begin
                if (bit_end) begin
                    bit_cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        tx_next      = cur_byte[bit_idx + 3'd1];
                    end
                end else begin
                    bit_cnt_next = bit_cnt + CNT_W'(1);
                end
            end

            STOP: begin
                if (bit_end) begin
                    bit_cnt_next = '0;
                    if (byte_idx == LAST_BYTE) begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        tx_next    = 1'b1;
                    end else begin
                        byte_idx_next  = byte_idx + BYTE_W'(1);
                        shift_buf_next = shift_buf << 8;
                        if (GAP_BITS > 0) begin
                            state_next = GAP;
                            tx_next    = 1'b1;
                        end else begin
                            state_next = START;
                            tx_next    = 1'b0;
                        end
                    end
                end else begin
                    bit_cnt_next = bit_cnt + CNT_W'(1);
                end
            end

            GAP: begin
                if (bit_cnt == GAP_END) begin
                    state_next   = START;
                    bit_cnt_next = '0;
                    tx_next      = 1'b0;
                end else begin
                    bit_cnt_next = bit_cnt + CNT_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_digit_tx.sv
// Bench for uart_digit_tx: one instance with the default one-bit gap, one with GAP_BITS=0
// for the contiguous back-to-back case; line levels are predicted from the frame format.
module tb_uart_digit_tx;

    localparam int CPB      = 10;
    localparam int BUSY_A   = 4 * 10 * CPB + 3 * CPB;
    localparam int CAPTURE  = 480;

    logic        clk = 1'b0;
    logic        rstA;
    logic        trigA;
    logic [31:0] digitsA;
    logic        txA;
    logic        busyA;
    logic        doneA;
    logic        rstB;
    logic        trigB;
    logic [31:0] digitsB;
    logic        txB;
    logic        busyB;
    logic        doneB;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] digits;
        logic [31:0] expBytes;
    } vec_t;

    vec_t tbl[5];

    always #5 clk = ~clk;

    uart_digit_tx #(.CLKS_PER_BIT(CPB), .NUM_BYTES(4), .GAP_BITS(1)) dutA (
        .iclk    (clk),
        .reset_n (rstA),
        .trig    (trigA),
        .digits  (digitsA),
        .uart_tx (txA),
        .busy    (busyA),
        .done    (doneA)
    );

    uart_digit_tx #(.CLKS_PER_BIT(CPB), .NUM_BYTES(4), .GAP_BITS(0)) dutB (
        .iclk    (clk),
        .reset_n (rstB),
        .trig    (trigB),
        .digits  (digitsB),
        .uart_tx (txB),
        .busy    (busyB),
        .done    (doneB)
    );

    // Line level expected during bit-time bt of a transmission of d: frames of start, 8 data bits
    // LSB first, stop, then gap idle bits; byte k is the k-th byte counting from the top of d.
    function automatic logic expBit(input logic [31:0] d, input int gap, input int bt);
        int frameLen;
        int k;
        int p;
        logic [31:0] b;
        frameLen = 10 + gap;
        k = bt / frameLen;
        p = bt % frameLen;
        if (bt < 0 || k >= 4) return 1'b1;
        b = (d >> (8 * (3 - k))) & 32'hFF;
        if (p == 0) return 1'b0;
        if (p <= 8) return b[p-1];
        return 1'b1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] d);
        @(negedge clk);
        trigA   = 1'b0;
        digitsA = d;
        @(negedge clk);
        trigA = 1'b1;
        @(posedge clk);
    endtask

    task automatic runTx(input string name, input logic [31:0] d, input logic [31:0] expBytes,
                         input bit disturb);
        logic txs [CAPTURE];
        int busyCycles;
        int doneCount;
        int doneAt;
        int lineErrs;
        int framingErrs;
        int base;
        logic [7:0] got;
        busyCycles  = 0;
        doneCount   = 0;
        doneAt      = -1;
        lineErrs    = 0;
        framingErrs = 0;
        applyStimulus(d);
        for (int c = 0; c < CAPTURE; c++) begin
            @(negedge clk);
            txs[c] = txA;
            if (busyA) busyCycles++;
            if (doneA) begin
                doneCount++;
                if (doneAt < 0) doneAt = c;
            end
            if (txA !== expBit(d, 1, c / CPB)) lineErrs++;
            if (disturb) begin
                if (c == 50) digitsA = 32'hFFFF_FFFF;
                if (c == 120 || c == 200 || c == 300) trigA = 1'b0;
                if (c == 121 || c == 201 || c == 301) trigA = 1'b1;
            end
        end
        for (int k = 0; k < 4; k++) begin
            base = k * 11 * CPB;
            for (int b = 0; b < 8; b++) got[b] = txs[base + (1 + b) * CPB + CPB / 2];
            if (txs[base + CPB / 2] !== 1'b0) framingErrs++;
            if (txs[base + 9 * CPB + CPB / 2] !== 1'b1) framingErrs++;
            if (k < 3 && txs[base + 10 * CPB + CPB / 2] !== 1'b1) framingErrs++;
            checkOutput($sformatf("%s byte%0d", name, k), {24'h0, got},
                        {24'h0, expBytes[31 - 8 * k -: 8]});
        end
        checkOutput($sformatf("%s framing", name), framingErrs, 0);
        checkOutput($sformatf("%s line", name), lineErrs, 0);
        checkOutput($sformatf("%s busy cycles", name), busyCycles, BUSY_A);
        checkOutput($sformatf("%s done count", name), doneCount, 1);
        checkOutput($sformatf("%s done cycle", name), doneAt, BUSY_A);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] dB1;
        logic [31:0] dB2;
        int doneSeen;
        int busySeen;
        int lineErrs;
        int busyErrs;
        int doneErrs;
        int busyTotal;
        logic expTx;
        logic expBusy;
        logic expDone;

        tbl[0] = '{32'h1234_5678, 32'h1234_5678};
        tbl[1] = '{32'hA0F0_9C3E, 32'hA0F0_9C3E};
        tbl[2] = '{32'h0000_0000, 32'h0000_0000};
        tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[4] = '{32'h0F1E_2D3C, 32'h0F1E_2D3C};

        dB1 = 32'h1357_9BDF;
        dB2 = 32'h2468_ACE0;

        rstA    = 1'b1;
        rstB    = 1'b1;
        trigA   = 1'b0;
        trigB   = 1'b1;
        digitsA = '0;
        digitsB = dB1;
        #1;
        rstA = 1'b0;
        rstB = 1'b0;
        #1;
        checkOutput("A reset outputs", {29'h0, txA, busyA, doneA}, 32'h4);
        checkOutput("B reset outputs", {29'h0, txB, busyB, doneB}, 32'h4);
        repeat (3) @(negedge clk);
        rstA = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("A idle after reset", {29'h0, txA, busyA, doneA}, 32'h4);

        for (int i = 0; i < 5; i++)
            runTx($sformatf("vec%0d", i), tbl[i].digits, tbl[i].expBytes, 1'b0);

        runTx("snapshot", 32'h1234_5678, 32'h1234_5678, 1'b1);

        for (int i = 0; i < 4; i++) begin
            d = $urandom();
            e = '0;
            for (int k = 0; k < 4; k++) e = (e << 8) | ((d >> (8 * (3 - k))) & 32'hFF);
            runTx($sformatf("rand%0d", i), d, e, 1'b0);
        end

        // Reset during byte 2, data bit 3 (bit-time 26 of the gapped stream).
        applyStimulus(32'h1234_5678);
        repeat (266) @(negedge clk);
        checkOutput("pre-reset line", {31'h0, txA}, {31'h0, expBit(32'h1234_5678, 1, 26)});
        #2;
        rstA = 1'b0;
        #1;
        checkOutput("async reset outputs", {29'h0, txA, busyA, doneA}, 32'h4);
        doneSeen = 0;
        busySeen = 0;
        repeat (5) @(negedge clk) begin
            if (doneA) doneSeen++;
        end
        trigA = 1'b0;
        rstA  = 1'b1;
        repeat (20) @(negedge clk) begin
            if (doneA) doneSeen++;
            if (busyA || !txA) busySeen++;
        end
        checkOutput("no done after reset", doneSeen, 0);
        checkOutput("idle after reset", busySeen, 0);
        runTx("retrigger", 32'h1234_5678, 32'h1234_5678, 1'b0);

        // Instance B: trig held through reset release, then re-raised in the done cycle.
        @(negedge clk);
        rstB = 1'b1;
        @(posedge clk);
        lineErrs  = 0;
        busyErrs  = 0;
        doneErrs  = 0;
        busyTotal = 0;
        for (int c = 0; c < 810; c++) begin
            @(negedge clk);
            if (c < 400) expTx = expBit(dB1, 0, c / CPB);
            else if (c == 400) expTx = 1'b1;
            else expTx = expBit(dB2, 0, (c - 401) / CPB);
            expBusy = (c < 400) || (c > 400 && c <= 800);
            expDone = (c == 400) || (c == 801);
            if (c == 0) checkOutput("B trig across reset", {30'h0, txB, busyB}, 32'h1);
            if (txB !== expTx) lineErrs++;
            if (busyB !== expBusy) busyErrs++;
            if (doneB !== expDone) doneErrs++;
            if (busyB) busyTotal++;
            if (c == 50) trigB = 1'b0;
            if (c == 400) begin
                trigB   = 1'b1;
                digitsB = dB2;
            end
        end
        checkOutput("B back-to-back line", lineErrs, 0);
        checkOutput("B busy timing", busyErrs, 0);
        checkOutput("B done timing", doneErrs, 0);
        checkOutput("B busy total", busyTotal, 800);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
